// File: rtl/regfile_sb_if.sv
// Decode/writeback-side bus of the register file: two read ports, two write ports,
// issue marking and scoreboard status. Plain combinational/edge signals, no handshake.
interface regfile_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SIZE  = 5
);
    logic [ADDR_SIZE-1:0]  RA1;
    logic [ADDR_SIZE-1:0]  RA2;
    logic [DATA_WIDTH-1:0] RD1;
    logic [DATA_WIDTH-1:0] RD2;
    logic                  WE3;
    logic [ADDR_SIZE-1:0]  WA3;
    logic [DATA_WIDTH-1:0] WD3;
    logic                  WE4;
    logic [ADDR_SIZE-1:0]  WA4;
    logic [DATA_WIDTH-1:0] WD4;
    logic                  ISS_EN;
    logic [ADDR_SIZE-1:0]  ISS_A;
    logic                  BUSY1;
    logic                  BUSY2;
    logic [ADDR_SIZE:0]    PEND_CNT;

    // No valid/ready: reads are sampled combinationally every cycle, writes and
    // issues take effect on the rising clock edge whenever their enable is high.
    modport master (
        output RA1, RA2, WE3, WA3, WD3, WE4, WA4, WD4, ISS_EN, ISS_A,
        input  RD1, RD2, BUSY1, BUSY2, PEND_CNT
    );

    modport slave (
        input  RA1, RA2, WE3, WA3, WD3, WE4, WA4, WD4, ISS_EN, ISS_A,
        output RD1, RD2, BUSY1, BUSY2, PEND_CNT
    );
endinterface

// File: rtl/regfile_sb.sv
// 2-read/2-write register file with per-register pending scoreboard (r0 hardwired zero).
// Optional write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SIZE  = 5
) (
    input  logic         CLK,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [DATA_WIDTH-1:0] r_rf [DEPTH];
    logic [DEPTH-1:0]      r_pend;
    logic [ADDR_SIZE:0]    r_pend_cnt;

    logic [DEPTH-1:0]      w_pend_nxt;
    logic [ADDR_SIZE:0]    w_cnt_nxt;
    logic                  w_wen_a;
    logic                  w_wen_b;
    logic [DATA_WIDTH-1:0] w_arr1;
    logic [DATA_WIDTH-1:0] w_arr2;

    assign w_wen_a = bus.WE3 && (bus.WA3 != '0);
    assign w_wen_b = bus.WE4 && (bus.WA4 != '0);

    // Issue beats a same-cycle writeback: the issued instruction is the newer producer.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 1; i < DEPTH; i++) begin
            if (bus.ISS_EN && (bus.ISS_A == ADDR_SIZE'(i))) begin
                w_pend_nxt[i] = 1'b1;
            end else if ((w_wen_a && (bus.WA3 == ADDR_SIZE'(i))) ||
                         (w_wen_b && (bus.WA4 == ADDR_SIZE'(i)))) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{ADDR_SIZE{1'b0}}, w_pend_nxt[i]};
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (w_wen_b && (bus.WA4 == ADDR_SIZE'(i))) begin
                    r_rf[i] <= bus.WD4;
                end else if (w_wen_a && (bus.WA3 == ADDR_SIZE'(i))) begin
                    r_rf[i] <= bus.WD3;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= w_cnt_nxt;
        end
    end

    assign w_arr1       = (bus.RA1 == '0) ? '0 : r_rf[bus.RA1];
    assign w_arr2       = (bus.RA2 == '0) ? '0 : r_rf[bus.RA2];
    assign bus.PEND_CNT = r_pend_cnt;

`ifdef REGFILE_BYPASS_EN
    logic w_hit_a1, w_hit_b1, w_hit_a2, w_hit_b2;
    logic w_iss1, w_iss2;

    // Write enables already exclude r0, so a hit implies RAn != 0.
    assign w_hit_a1 = w_wen_a && (bus.WA3 == bus.RA1);
    assign w_hit_b1 = w_wen_b && (bus.WA4 == bus.RA1);
    assign w_hit_a2 = w_wen_a && (bus.WA3 == bus.RA2);
    assign w_hit_b2 = w_wen_b && (bus.WA4 == bus.RA2);
    assign w_iss1   = bus.ISS_EN && (bus.ISS_A == bus.RA1);
    assign w_iss2   = bus.ISS_EN && (bus.ISS_A == bus.RA2);

    assign bus.RD1   = w_hit_b1 ? bus.WD4 : (w_hit_a1 ? bus.WD3 : w_arr1);
    assign bus.RD2   = w_hit_b2 ? bus.WD4 : (w_hit_a2 ? bus.WD3 : w_arr2);
    assign bus.BUSY1 = (w_hit_a1 || w_hit_b1) ? w_iss1 : r_pend[bus.RA1];
    assign bus.BUSY2 = (w_hit_a2 || w_hit_b2) ? w_iss2 : r_pend[bus.RA2];
`else
    assign bus.RD1   = w_arr1;
    assign bus.RD2   = w_arr2;
    assign bus.BUSY1 = r_pend[bus.RA1];
    assign bus.BUSY2 = r_pend[bus.RA2];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed + randomized bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AW)) bus ();
  regfile_sb #(.DATA_WIDTH(DW), .ADDR_SIZE(AW)) dut (
    .CLK  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] m_rf [DEPTH];
  bit            m_p  [DEPTH];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_p[i]);
    return n;
  endfunction

  function automatic bit m_wr_hits(input logic [AW-1:0] ra);
    return ((bus.WE3 == 1'b1) && (bus.WA3 == ra)) || ((bus.WE4 == 1'b1) && (bus.WA4 == ra));
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] ra);
    if (ra == '0) return '0;
    if (BYPASS && bus.WE4 && (bus.WA4 == ra)) return bus.WD4;
    if (BYPASS && bus.WE3 && (bus.WA3 == ra)) return bus.WD3;
    return m_rf[ra];
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] ra);
    if (ra == '0) return 1'b0;
    if (BYPASS && m_wr_hits(ra)) return bus.ISS_EN && (bus.ISS_A == ra);
    return m_p[ra];
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_rf[i] = '0;
      m_p[i]  = 1'b0;
    end
  endfunction

  // Rules applied in order of increasing priority: port A, port B, then issue.
  function automatic void m_edge();
    if (bus.WE3) begin m_rf[bus.WA3] = bus.WD3; m_p[bus.WA3] = 1'b0; end
    if (bus.WE4) begin m_rf[bus.WA4] = bus.WD4; m_p[bus.WA4] = 1'b0; end
    if (bus.ISS_EN) m_p[bus.ISS_A] = 1'b1;
    m_rf[0] = '0;
    m_p[0]  = 1'b0;
  endfunction

  task automatic idle();
    bus.RA1 = '0; bus.RA2 = '0;
    bus.WE3 = 1'b0; bus.WA3 = '0; bus.WD3 = '0;
    bus.WE4 = 1'b0; bus.WA4 = '0; bus.WD4 = '0;
    bus.ISS_EN = 1'b0; bus.ISS_A = '0;
  endtask

  task automatic cycle(input string tag);
    #1;
    chk($sformatf("%s.rd1", tag),   bus.RD1, m_rd(bus.RA1));
    chk($sformatf("%s.rd2", tag),   bus.RD2, m_rd(bus.RA2));
    chk($sformatf("%s.busy1", tag), DW'(bus.BUSY1), DW'(m_busy(bus.RA1)));
    chk($sformatf("%s.busy2", tag), DW'(bus.BUSY2), DW'(m_busy(bus.RA2)));
    chk($sformatf("%s.pcnt", tag),  DW'(bus.PEND_CNT), DW'(m_cnt()));
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    m_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.RA1 = 5'd5;
    #1 chk("reset_pcnt", DW'(bus.PEND_CNT), 32'd0);
    cycle("reset");

    // Asynchronous reset clears data and scoreboard without a clock edge.
    bus.WE3 = 1'b1; bus.WA3 = 5'd5; bus.WD3 = 32'h1234;
    bus.ISS_EN = 1'b1; bus.ISS_A = 5'd10;
    cycle("t1_wr");
    idle(); bus.RA1 = 5'd5;
    #1 chk("t1_rd_before", bus.RD1, 32'h1234);
    chk("t1_cnt_before", DW'(bus.PEND_CNT), 32'd1);
    #1 rst_n = 1'b0;
    m_clear();
    #1 chk("t1_async_rd", bus.RD1, 32'h0);
    chk("t1_async_cnt", DW'(bus.PEND_CNT), 32'd0);
    bus.WE3 = 1'b1; bus.WA3 = 5'd5; bus.WD3 = 32'h99;
    bus.ISS_EN = 1'b1; bus.ISS_A = 5'd5;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); bus.RA1 = 5'd5;
    #1 chk("t1_drop_rd", bus.RD1, 32'h0);
    chk("t1_drop_busy", DW'(bus.BUSY1), 32'd0);
    chk("t1_drop_cnt", DW'(bus.PEND_CNT), 32'd0);
    cycle("t1_post");

    // Dual write to one address: port B wins; r0 ignores writes.
    bus.WE3 = 1'b1; bus.WA3 = 5'd7; bus.WD3 = 32'hAAAA;
    bus.WE4 = 1'b1; bus.WA4 = 5'd7; bus.WD4 = 32'h5555;
    cycle("t2_dual");
    idle(); bus.RA1 = 5'd7; bus.RA2 = 5'd0;
    bus.WE3 = 1'b1; bus.WA3 = 5'd0; bus.WD3 = 32'hFFFF;
    #1 chk("t2_dual_rd", bus.RD1, 32'h5555);
    chk("t2_r0_rd", bus.RD2, 32'h0);
    cycle("t2_r0wr");
    idle(); bus.RA1 = 5'd0;
    #1 chk("t2_r0_after", bus.RD1, 32'h0);
    cycle("t2_post");

    // Scoreboard set/clear and re-issue of a pending register.
    bus.ISS_EN = 1'b1; bus.ISS_A = 5'd3; cycle("t3_iss3");
    bus.ISS_A = 5'd4; cycle("t3_iss4");
    idle(); bus.RA1 = 5'd3; bus.RA2 = 5'd4;
    #1 chk("t3_cnt2", DW'(bus.PEND_CNT), 32'd2);
    chk("t3_busy3", DW'(bus.BUSY1), 32'd1);
    bus.WE3 = 1'b1; bus.WA3 = 5'd3; bus.WD3 = 32'h33;
    cycle("t3_wb3");
    idle(); bus.RA1 = 5'd3;
    #1 chk("t3_cnt1", DW'(bus.PEND_CNT), 32'd1);
    chk("t3_busy3_clr", DW'(bus.BUSY1), 32'd0);
    bus.ISS_EN = 1'b1; bus.ISS_A = 5'd4; cycle("t3_reiss4");
    idle();
    #1 chk("t3_reiss_cnt", DW'(bus.PEND_CNT), 32'd1);

    // Issue and writeback to the same register in one cycle.
    bus.ISS_EN = 1'b1; bus.ISS_A = 5'd9;
    bus.WE4 = 1'b1; bus.WA4 = 5'd9; bus.WD4 = 32'h77;
    cycle("t4_simul");
    idle(); bus.RA1 = 5'd9;
    #1 chk("t4_rd9", bus.RD1, 32'h77);
    chk("t4_busy9", DW'(bus.BUSY1), 32'd1);
    chk("t4_cnt", DW'(bus.PEND_CNT), 32'd2);
    bus.ISS_EN = 1'b1; bus.ISS_A = 5'd0; cycle("t4_iss0");
    idle();
    #1 chk("t4_iss0_cnt", DW'(bus.PEND_CNT), 32'd2);

    // Read of a register being written this cycle.
    bus.ISS_EN = 1'b1; bus.ISS_A = 5'd6; cycle("t5_iss6");
    idle(); bus.RA1 = 5'd6;
    bus.WE3 = 1'b1; bus.WA3 = 5'd6; bus.WD3 = 32'hBEEF;
`ifdef REGFILE_BYPASS_EN
    #1 chk("t5_byp_rd", bus.RD1, 32'hBEEF);
    chk("t5_byp_busy", DW'(bus.BUSY1), 32'd0);
`else
    #1 chk("t5_nobyp_rd", bus.RD1, 32'h0);
    chk("t5_nobyp_busy", DW'(bus.BUSY1), 32'd1);
`endif
    cycle("t5_wr6");
    idle(); bus.RA1 = 5'd6;
    #1 chk("t5_after_rd", bus.RD1, 32'hBEEF);
    chk("t5_after_cnt", DW'(bus.PEND_CNT), 32'd2);

    // Fill the scoreboard, re-issue at full, then drain two per cycle.
    for (int r = 1; r < DEPTH; r++) begin
      idle(); bus.ISS_EN = 1'b1; bus.ISS_A = AW'(r); bus.RA1 = AW'(r);
      cycle("t6_fill");
    end
    idle();
    #1 chk("t6_full", DW'(bus.PEND_CNT), 32'd31);
    bus.ISS_EN = 1'b1; bus.ISS_A = 5'd17; cycle("t6_reiss");
    idle();
    #1 chk("t6_full_hold", DW'(bus.PEND_CNT), 32'd31);
    for (int r = 1; r < DEPTH; r += 2) begin
      idle();
      bus.WE3 = 1'b1; bus.WA3 = AW'(r); bus.WD3 = $urandom;
      if (r + 1 < DEPTH) begin
        bus.WE4 = 1'b1; bus.WA4 = AW'(r + 1); bus.WD4 = $urandom;
      end
      bus.RA1 = AW'(r); bus.RA2 = AW'(r + 1);
      cycle("t6_drain");
    end
    idle();
    #1 chk("t6_empty", DW'(bus.PEND_CNT), 32'd0);
    cycle("t6_post");

    // Random traffic, reads biased toward in-flight write addresses.
    for (int n = 0; n < 400; n++) begin
      bus.WE3    = ($urandom_range(0, 9) < 5);
      bus.WA3    = AW'($urandom_range(0, DEPTH - 1));
      bus.WD3    = $urandom;
      bus.WE4    = ($urandom_range(0, 9) < 4);
      bus.WA4    = ($urandom_range(0, 3) == 0) ? bus.WA3 : AW'($urandom_range(0, DEPTH - 1));
      bus.WD4    = $urandom;
      bus.ISS_EN = ($urandom_range(0, 9) < 4);
      bus.ISS_A  = ($urandom_range(0, 4) == 0) ? bus.WA4 : AW'($urandom_range(0, DEPTH - 1));
      bus.RA1    = ($urandom_range(0, 2) == 0) ? bus.WA3 : AW'($urandom_range(0, DEPTH - 1));
      bus.RA2    = ($urandom_range(0, 2) == 0) ? bus.WA4 : AW'($urandom_range(0, DEPTH - 1));
      cycle("rand");
    end
    idle();
    cycle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
